fetch_controller: RTL

FETCH_CONTROLLER -- requirements
Module: fetch_controller

---
 rtl/vr16_pkg.sv | 16 +
 rtl/fetch_return_stack.sv | 91 +++++++++
 rtl/fetch_controller.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/vr16_pkg.sv
// Shared widths, default reset vector and fetch FSM state type for the vr16 front end.
package vr16_pkg;

   localparam int unsigned ADDR_W  = 16;
   localparam int unsigned INSTR_W = 16;

   localparam logic [ADDR_W-1:0] DEFAULT_RESET_VECTOR = 16'h0000;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      HOLD,
      REDIRECT
   } fetch_state_t;

endpackage

// File: rtl/fetch_return_stack.sv
// Return-address storage for call/return redirects.
// FETCH_RAS_EN selects a RAS_DEPTH-entry LIFO; otherwise a single link register.
module fetch_return_stack
   import vr16_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
   parameter int unsigned       RAS_DEPTH    = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [ADDR_W-1:0] push_addr,
`ifdef FETCH_RAS_EN
   input  logic              pop,
`endif
   output logic [ADDR_W-1:0] top_addr_c,
   output logic              error
);

   if (RAS_DEPTH < 1) begin : g_depth_check
      $error("fetch_return_stack: RAS_DEPTH must be at least 1");
   end

`ifdef FETCH_RAS_EN

   localparam int unsigned       PTR_W    = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int unsigned       CNT_W    = $clog2(RAS_DEPTH + 1);
   localparam logic [PTR_W-1:0]  LAST_IDX = PTR_W'(RAS_DEPTH - 1);
   localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(RAS_DEPTH);

   logic [ADDR_W-1:0] entries [RAS_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr_c;
   logic [CNT_W-1:0]  count;

   // Circular buffer: a push when full overwrites the oldest entry.
   always_comb begin
      rd_ptr_c   = (wr_ptr == '0) ? LAST_IDX : wr_ptr - PTR_W'(1);
      top_addr_c = (count == '0) ? RESET_VECTOR : entries[rd_ptr_c];
   end

   always_ff @(posedge clk) begin
      if (push && !reset) begin
         entries[wr_ptr] <= push_addr;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         count  <= '0;
         error  <= 1'b0;
      end else begin
         error <= 1'b0;
         if (push) begin
            wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + PTR_W'(1);
            if (count == FULL_CNT) begin
               error <= 1'b1;
            end else begin
               count <= count + CNT_W'(1);
            end
         end else if (pop) begin
            if (count == '0) begin
               error <= 1'b1;
            end else begin
               wr_ptr <= rd_ptr_c;
               count  <= count - CNT_W'(1);
            end
         end
      end
   end

`else

   logic [ADDR_W-1:0] link;

   // Return reads the link without consuming it.
   always_ff @(posedge clk) begin
      if (reset) begin
         link <= RESET_VECTOR;
      end else if (push) begin
         link <= push_addr;
      end
   end

   assign top_addr_c = link;
   assign error      = 1'b0;

`endif

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch front end: sequential fetch, 1-entry skid, call/jump/return redirects.
// Define FETCH_RAS_EN for a RAS_DEPTH-entry return stack instead of a single link register.
module fetch_controller
   import vr16_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
   parameter int unsigned       RAS_DEPTH    = 4
) (
   input  logic               clk,
   input  logic               reset,
   output logic [ADDR_W-1:0]  imem_address,
   output logic               imem_enable,
   input  logic [INSTR_W-1:0] imem_instruction,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic               instr_valid,
   input  logic               instr_ready,
   input  logic               jump_enable,
   input  logic               call_enable,
   input  logic [ADDR_W-1:0]  jump_address,
   input  logic               return_enable,
   output logic               ras_error
);

   fetch_state_t state, next_state;

   logic [ADDR_W-1:0]  fetch_addr;
   logic [ADDR_W-1:0]  inflight_pc;
   logic [ADDR_W-1:0]  skid_pc;
   logic [INSTR_W-1:0] skid_instr;
   logic               inflight;
   logic               skid_valid;

   logic               transfer_c;
   logic               call_c;
   logic               jump_c;
   logic               return_c;
   logic               redirect_c;
   logic               issue_c;
   logic               room_c;
   logic [1:0]         occ_c;
   logic [1:0]         next_occ_c;
   logic [ADDR_W-1:0]  target_c;
   logic [ADDR_W-1:0]  push_addr_c;
   logic [ADDR_W-1:0]  ras_top_c;

   fetch_return_stack #(
      .RESET_VECTOR (RESET_VECTOR),
      .RAS_DEPTH    (RAS_DEPTH)
   ) u_return_stack (
      .clk        (clk),
      .reset      (reset),
      .push       (call_c),
      .push_addr  (push_addr_c),
`ifdef FETCH_RAS_EN
      .pop        (return_c),
`endif
      .top_addr_c (ras_top_c),
      .error      (ras_error)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Redirect decode, occupancy-based issue and next state.
   always_comb begin
      next_state  = state;
      issue_c     = 1'b0;
      transfer_c  = instr_valid && instr_ready;
      call_c      = transfer_c && call_enable;
      jump_c      = transfer_c && !call_enable && jump_enable;
      return_c    = transfer_c && !call_enable && !jump_enable && return_enable;
      redirect_c  = call_c || jump_c || return_c;
      target_c    = return_c ? ras_top_c : jump_address;
      push_addr_c = instr_pc + ADDR_W'(1);
      occ_c       = 2'(instr_valid) + 2'(skid_valid) + 2'(inflight);
      room_c      = (occ_c - 2'(transfer_c)) < 2'd2;
      next_occ_c  = occ_c;

      case (state)
         IDLE, REDIRECT: begin
            // Pipeline is known empty here, so the fetch address issues unconditionally.
            issue_c    = !reset;
            next_state = RUN;
         end
         default: begin
            issue_c    = !reset && room_c;
            next_occ_c = occ_c - 2'(transfer_c) + 2'(issue_c);
            next_state = (next_occ_c >= 2'd2) ? HOLD : RUN;
         end
      endcase

      if (redirect_c) begin
         next_state = REDIRECT;
      end
   end

   assign imem_enable  = issue_c;
   assign imem_address = fetch_addr;

   // Returned data fills the output register first, the skid entry when the output is stalled.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_addr  <= RESET_VECTOR;
         inflight    <= 1'b0;
         inflight_pc <= '0;
         skid_valid  <= 1'b0;
         skid_instr  <= '0;
         skid_pc     <= '0;
         instr_valid <= 1'b0;
         instr       <= '0;
         instr_pc    <= '0;
      end else begin
         inflight <= issue_c && !redirect_c;
         if (issue_c) begin
            inflight_pc <= fetch_addr;
            fetch_addr  <= fetch_addr + ADDR_W'(1);
         end

         if (redirect_c) begin
            fetch_addr  <= target_c;
            instr_valid <= 1'b0;
            skid_valid  <= 1'b0;
         end else if (!instr_valid || transfer_c) begin
            if (skid_valid) begin
               instr       <= skid_instr;
               instr_pc    <= skid_pc;
               instr_valid <= 1'b1;
               skid_valid  <= inflight;
               if (inflight) begin
                  skid_instr <= imem_instruction;
                  skid_pc    <= inflight_pc;
               end
            end else begin
               instr_valid <= inflight;
               if (inflight) begin
                  instr    <= imem_instruction;
                  instr_pc <= inflight_pc;
               end
            end
         end else if (inflight) begin
            skid_instr <= imem_instruction;
            skid_pc    <= inflight_pc;
            skid_valid <= 1'b1;
         end
      end
   end

endmodule
